// File: rtl/nmcu_mem_arbiter_if.sv
// nmcu_mem_arbiter_if: bundle of the arbiter's requester-side and memory-side buses.
//   requester side : req_sel, req_w, req_addr, req_wdata (flattened, requester k at
//                    [k*W +: W]), req_ready, req_rdata (shared)
//   memory side    : mem_sel, mem_w, mem_addr, mem_wdata, mem_rdata, mem_ready
//   status         : grant (one-hot owner), timeout_err, err_idx
// modport slave is taken by the arbiter; modport master is the environment
// (requesters plus memory) that drives the arbiter.
interface nmcu_mem_arbiter_if #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned ADDR_WIDTH    = 16,
  parameter int unsigned DATABUS_WIDTH = 32
);
  logic [NUM_REQ-1:0]               req_sel;
  logic [NUM_REQ-1:0]               req_w;
  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr;
  logic [NUM_REQ*DATABUS_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]               req_ready;
  logic [DATABUS_WIDTH-1:0]         req_rdata;
  logic                             mem_sel;
  logic                             mem_w;
  logic [ADDR_WIDTH-1:0]            mem_addr;
  logic [DATABUS_WIDTH-1:0]         mem_wdata;
  logic [DATABUS_WIDTH-1:0]         mem_rdata;
  logic                             mem_ready;
  logic [NUM_REQ-1:0]               grant;
  logic                             timeout_err;
  logic [$clog2(NUM_REQ)-1:0]       err_idx;

  modport master (
    output req_sel, req_w, req_addr, req_wdata, mem_rdata, mem_ready,
    input  req_ready, req_rdata, mem_sel, mem_w, mem_addr, mem_wdata,
           grant, timeout_err, err_idx
  );

  modport slave (
    input  req_sel, req_w, req_addr, req_wdata, mem_rdata, mem_ready,
    output req_ready, req_rdata, mem_sel, mem_w, mem_addr, mem_wdata,
           grant, timeout_err, err_idx
  );
endinterface

// File: rtl/nmcu_mem_arbiter.sv
// nmcu_mem_arbiter: round-robin arbiter sharing one memory port among NUM_REQ
// requesters using the NMCU single-transaction handshake. One access at a time,
// followed by one idle RELEASE cycle.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - nmcu_mem_arbiter_if.slave (requester ports, memory port, grant/error status)
// Optional feature: define ARB_TIMEOUT_EN to enable the grant watchdog
// (TIMEOUT_CYCLES); otherwise timeout_err and err_idx are tied to 0.
module nmcu_mem_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned DATABUS_WIDTH  = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic              clk,
  input logic              rst,
  nmcu_mem_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BUSY    = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  // Reject parameter sets the design is not built for.
  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("nmcu_mem_arbiter: unsupported NUM_REQ or TIMEOUT_CYCLES");
  end

  logic [1:0]               state, state_next;
  logic [IDX_W-1:0]         gnt_idx, gnt_idx_next;
  logic [IDX_W-1:0]         rr_ptr, rr_ptr_next;
  logic [IDX_W-1:0]         rr_adv;
  logic [IDX_W-1:0]         cand;
  logic                     found;

  logic                     mem_sel;
  logic                     mem_w;
  logic [ADDR_WIDTH-1:0]    mem_addr;
  logic [DATABUS_WIDTH-1:0] mem_wdata;
  logic [NUM_REQ-1:0]       req_ready;
  logic [DATABUS_WIDTH-1:0] req_rdata;
  logic [NUM_REQ-1:0]       grant;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;
  logic [CNT_W-1:0]         cnt, cnt_next;
  logic                     timeout_err, timeout_err_next;
  logic [IDX_W-1:0]         err_idx, err_idx_next;
`endif

  // State and bookkeeping registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      gnt_idx <= '0;
      rr_ptr  <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt         <= '0;
      timeout_err <= 1'b0;
      err_idx     <= '0;
`endif
    end else begin
      state   <= state_next;
      gnt_idx <= gnt_idx_next;
      rr_ptr  <= rr_ptr_next;
`ifdef ARB_TIMEOUT_EN
      cnt         <= cnt_next;
      timeout_err <= timeout_err_next;
      err_idx     <= err_idx_next;
`endif
    end
  end

  // Next-state selection and the combinational memory/requester muxes.
  always_comb begin
    state_next   = state;
    gnt_idx_next = gnt_idx;
    rr_ptr_next  = rr_ptr;
    cand         = '0;
    found        = 1'b0;
    mem_sel      = 1'b0;
    mem_w        = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    req_ready    = '0;
    req_rdata    = '0;
    grant        = '0;
    rr_adv       = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
`ifdef ARB_TIMEOUT_EN
    cnt_next         = cnt;
    timeout_err_next = 1'b0;
    err_idx_next     = err_idx;
`endif

    case (state)
      ST_IDLE: begin
        // First active requester at or after rr_ptr, wrapping.
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
          cand = IDX_W'((32'(rr_ptr) + i) % NUM_REQ);
          if (!found && bus.req_sel[cand]) begin
            found        = 1'b1;
            gnt_idx_next = cand;
            state_next   = ST_BUSY;
          end
        end
`ifdef ARB_TIMEOUT_EN
        cnt_next = '0;
`endif
      end

      ST_BUSY: begin
        mem_sel            = 1'b1;
        grant[gnt_idx]     = 1'b1;
        mem_w              = bus.req_w[gnt_idx];
        req_rdata          = bus.mem_rdata;
        req_ready[gnt_idx] = bus.mem_ready;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
          if (IDX_W'(k) == gnt_idx) begin
            mem_addr  = bus.req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
            mem_wdata = bus.req_wdata[k*DATABUS_WIDTH +: DATABUS_WIDTH];
          end
        end

        // Completion wins over abandonment and over the watchdog.
        if (bus.mem_ready) begin
          rr_ptr_next = rr_adv;
          state_next  = ST_RELEASE;
        end else if (!bus.req_sel[gnt_idx]) begin
          rr_ptr_next = rr_adv;
          state_next  = ST_IDLE;
        end else begin
`ifdef ARB_TIMEOUT_EN
          if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            rr_ptr_next      = rr_adv;
            state_next       = ST_RELEASE;
            timeout_err_next = 1'b1;
            err_idx_next     = gnt_idx;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
`endif
        end
      end

      ST_RELEASE: state_next = ST_IDLE;

      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.mem_sel   = mem_sel;
  assign bus.mem_w     = mem_w;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.req_ready = req_ready;
  assign bus.req_rdata = req_rdata;
  assign bus.grant     = grant;

`ifdef ARB_TIMEOUT_EN
  assign bus.timeout_err = timeout_err;
  assign bus.err_idx     = err_idx;
`else
  assign bus.timeout_err = 1'b0;
  assign bus.err_idx     = '0;
`endif

endmodule
